// File: rtl/rv_pkg.sv
// ----------------------------------------------------------------------------
// rv_pkg
//   Shared types and sizes for the register-file writeback path.
//   XLEN      : width of a register value
//   NREG      : number of architectural registers (x0 is hardwired to zero)
//   REG_IDX_W : width of a register index
//   reg_idx_t : register index type
//   wb_req_t  : one writeback request (destination + data)
// ----------------------------------------------------------------------------
package rv_pkg;

  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = $clog2(NREG);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t          rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  // x0 is never written and never tracked as pending.
  function automatic logic is_x0(input reg_idx_t idx);
    return (idx == '0);
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// ----------------------------------------------------------------------------
// wb_scoreboard
//   Tracks which registers have an outstanding write and answers hazard
//   queries from decode.
//
// Ports
//   clk, reset          : clock / asynchronous active-low reset
//   issue_valid/rd      : decode announces an instruction that will write rd
//   issue_ready         : issue accepted (rd not pending, or retired this cycle)
//   clr_valid/clr_rd    : a writeback grant this cycle, retiring clr_rd
//   rs1, rs2            : read indices from decode
//   rs1_busy, rs2_busy  : the corresponding register still has a pending write
// ----------------------------------------------------------------------------
module wb_scoreboard
  import rv_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  output logic                 issue_ready,
  input  logic                 clr_valid,
  input  logic [REG_IDX_W-1:0] clr_rd,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;
  logic            set_en;
  logic            clr_hits_issue;

  // A register that is retired on this very edge can be re-claimed by a new
  // issue in the same cycle; otherwise a pending register refuses the issue
  // so two in-flight writes never target the same register.
  assign clr_hits_issue = clr_valid && (clr_rd == issue_rd);
  assign issue_ready    = !pending_q[issue_rd] || clr_hits_issue;
  assign set_en         = issue_valid && issue_ready && !is_x0(issue_rd);

  // x0 never becomes pending.
  assign pending_d[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_pend
      logic set_hit;
      logic clr_hit;
      assign set_hit = set_en && (issue_rd == REG_IDX_W'(gi));
      assign clr_hit = clr_valid && (clr_rd == REG_IDX_W'(gi));
      // Set has priority: the new owner claims the register as the old
      // write retires.
      assign pending_d[gi] = set_hit ? 1'b1 :
                             clr_hit ? 1'b0 : pending_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // No bypass from the write stage: busy reflects the pending vector only.
  assign rs1_busy = !is_x0(rs1) && pending_q[rs1];
  assign rs2_busy = !is_x0(rs2) && pending_q[rs2];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the register file's single write port between the ALU writeback
//   (port A) and the LSU / multicycle writeback (port B). Port A normally has
//   priority; port B is forced a grant after losing STARVE_LIMIT consecutive
//   contested cycles. The granted request is registered and presented to the
//   register file one cycle later. A scoreboard tracks outstanding writes and
//   reports read hazards.
//
// Parameters
//   STARVE_LIMIT : contested cycles port B may lose before it must win (>=1)
//
// Ports
//   clk, reset                 : clock / asynchronous active-low reset
//   issue_valid/rd, issue_ready: decode claims a destination register
//   a_valid/rd/data, a_ready   : port A writeback handshake
//   b_valid/rd/data, b_ready   : port B writeback handshake
//   rs1, rs2, rs1_busy/rs2_busy: read hazard query
//   rd, write_data, RegWrite   : registered register-file write port
// ----------------------------------------------------------------------------
module regfile_wb_arbiter
  import rv_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  output logic                 issue_ready,
  input  logic                 a_valid,
  input  logic [REG_IDX_W-1:0] a_rd,
  input  logic [XLEN-1:0]      a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [REG_IDX_W-1:0] b_rd,
  input  logic [XLEN-1:0]      b_data,
  output logic                 b_ready,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic [REG_IDX_W-1:0] rd,
  output logic [XLEN-1:0]      write_data,
  output logic                 RegWrite
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  // ---------------------------------------------------------------- arbiter
  logic [STARVE_W-1:0] starve_q;
  logic [STARVE_W-1:0] starve_d;
  logic                grant_a;
  logic                grant_b;
  logic                grant_any;
  wb_req_t             grant_req;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_valid && b_valid) begin
      if (starve_q >= STARVE_MAX) begin
        grant_b = 1'b1;
      end else begin
        grant_a = 1'b1;
      end
    end else begin
      grant_a = a_valid;
      grant_b = b_valid;
    end
  end

  assign grant_any = grant_a || grant_b;
  assign a_ready   = grant_a;
  assign b_ready   = grant_b;

  always_comb begin
    grant_req.rd   = a_rd;
    grant_req.data = a_data;
    if (grant_b) begin
      grant_req.rd   = b_rd;
      grant_req.data = b_data;
    end
  end

  // The counter only measures an unbroken run of contested losses by B:
  // any cycle where B is idle or wins starts the run over.
  always_comb begin
    starve_d = starve_q;
    if (!b_valid || grant_b) begin
      starve_d = '0;
    end else if (grant_a) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  // ------------------------------------------------------------ write stage
  wb_req_t wb_q;
  wb_req_t wb_d;
  logic    regwrite_q;
  logic    regwrite_d;

  // Without a grant the address/data hold and only the strobe drops. A grant
  // to x0 is consumed like any other but never strobes the register file.
  always_comb begin
    wb_d       = wb_q;
    regwrite_d = 1'b0;
    if (grant_any) begin
      wb_d       = grant_req;
      regwrite_d = !is_x0(grant_req.rd);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q   <= '0;
      wb_q       <= '0;
      regwrite_q <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      wb_q       <= wb_d;
      regwrite_q <= regwrite_d;
    end
  end

  assign rd         = wb_q.rd;
  assign write_data = wb_q.data;
  assign RegWrite   = regwrite_q;

  // ------------------------------------------------------------- scoreboard
  // The pending bit is retired on the grant edge, i.e. as the write is
  // staged, not when the register file commits it.
  wb_scoreboard u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .clr_valid   (grant_any),
    .clr_rd      (grant_req.rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        issue_ready;
  logic        a_valid = 1'b0;
  logic [4:0]  a_rd = '0;
  logic [31:0] a_data = '0;
  logic        a_ready;
  logic        b_valid = 1'b0;
  logic [4:0]  b_rd = '0;
  logic [31:0] b_data = '0;
  logic        b_ready;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic        RegWrite;

  regfile_wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .a_valid     (a_valid),
    .a_rd        (a_rd),
    .a_data      (a_data),
    .a_ready     (a_ready),
    .b_valid     (b_valid),
    .b_rd        (b_rd),
    .b_data      (b_data),
    .b_ready     (b_ready),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .rd          (rd),
    .write_data  (write_data),
    .RegWrite    (RegWrite)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference state: which registers have an outstanding write, and how many
  // contested cycles in a row B has lost.
  bit [31:0] pend = '0;
  int        b_losses = 0;

  typedef struct {
    int          due;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  // Values seen during the last step
  logic s_a_ready, s_b_ready, s_issue_ready, s_rs1_busy, s_regwrite;
  logic [4:0]  s_rd;
  logic [31:0] s_wdata;
  logic m_ga = 1'b0;
  logic m_gb = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle of stimulus; the model decides the expected handshake,
  // hazard flags and the write that must appear on the next cycle.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                      input logic bv, input logic [4:0] brd, input logic [31:0] bdat,
                      input logic iv, input logic [4:0] ird,
                      input logic [4:0] r1, input logic [4:0] r2);
    logic ga, gb, exp_ir;
    logic [4:0]  grd;
    logic [31:0] gdat;
    @(posedge clk);
    #1;
    a_valid = av; a_rd = ard; a_data = adat;
    b_valid = bv; b_rd = brd; b_data = bdat;
    issue_valid = iv; issue_rd = ird;
    rs1 = r1; rs2 = r2;
    #2;
    ga = 1'b0;
    gb = 1'b0;
    if (av && bv) begin
      if (b_losses < STARVE_LIMIT) begin
        ga = 1'b1;
        b_losses++;
      end else begin
        gb = 1'b1;
        b_losses = 0;
      end
    end else begin
      ga = av;
      gb = bv;
      b_losses = 0;
    end
    grd  = ga ? ard : brd;
    gdat = ga ? adat : bdat;
    exp_ir = (ird == 5'd0) || !pend[ird] || ((ga || gb) && (grd == ird));
    chk("a_ready", 32'(a_ready), 32'(ga));
    chk("b_ready", 32'(b_ready), 32'(gb));
    chk("issue_ready", 32'(issue_ready), 32'(exp_ir));
    chk("rs1_busy", 32'(rs1_busy), 32'((r1 != 5'd0) && pend[r1]));
    chk("rs2_busy", 32'(rs2_busy), 32'((r2 != 5'd0) && pend[r2]));
    s_a_ready = a_ready; s_b_ready = b_ready; s_issue_ready = issue_ready;
    s_rs1_busy = rs1_busy; s_regwrite = RegWrite; s_rd = rd; s_wdata = write_data;
    if (ga || gb) begin
      if (grd != 5'd0) exp_q.push_back('{cyc + 1, grd, gdat});
      pend[grd] = 1'b0;
    end
    if (iv && exp_ir && ird != 5'd0) pend[ird] = 1'b1;
    m_ga = ga;
    m_gb = gb;
  endtask

  task automatic idle(input logic [4:0] r1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, r1, 5'd0);
  endtask

  // Monitor: every cycle the write port must show exactly the write due now.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        chk("wb_regwrite", 32'(RegWrite), 32'd1);
        chk("wb_rd", 32'(rd), 32'(exp_q[0].rd));
        chk("wb_data", write_data, exp_q[0].data);
        void'(exp_q.pop_front());
      end else begin
        chk("wb_idle", 32'(RegWrite), 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ra_v, rb_v;
    logic [4:0]  ra_rd, rb_rd;
    logic [31:0] ra_d, rb_d;

    // Power-on reset
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rs1 = 5'd3;
    #1;
    chk("reset_regwrite", 32'(RegWrite), 32'd0);
    chk("reset_rd", 32'(rd), 32'd0);
    chk("reset_wdata", write_data, 32'd0);
    chk("reset_busy", 32'(rs1_busy), 32'd0);
    reset = 1'b1;
    mon_en = 1'b1;

    // A-only write
    step(1'b1, 5'd5, 32'hA47DEFFF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("a_only_ready", 32'(s_a_ready), 32'd1);
    idle(5'd0);
    chk("a_only_regwrite", 32'(s_regwrite), 32'd1);
    chk("a_only_rd", 32'(s_rd), 32'd5);
    chk("a_only_data", s_wdata, 32'hA47DEFFF);

    // Starvation pattern A,A,A,A,B (B held, A streams new data)
    idle(5'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 5'd3, 32'h1000_0000 + 32'(i), 1'b1, 5'd4, 32'hBBBB_0000 + 32'(i / 5),
           1'b0, 5'd0, 5'd0, 5'd0);
      chk("starve_pattern", 32'(s_a_ready), 32'((i % 5) != 4));
    end

    // Scoreboard: issue, WAW refusal, retire by B, re-issue
    idle(5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 5'd2, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 5'd2, 5'd0);
    chk("rs1_busy_after_issue", 32'(s_rs1_busy), 32'd1);
    chk("waw_refused", 32'(s_issue_ready), 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h3EDCBA00, 1'b0, 5'd0, 5'd2, 5'd0);
    chk("b_write_ready", 32'(s_b_ready), 32'd1);
    chk("busy_no_bypass", 32'(s_rs1_busy), 32'd1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 5'd2, 5'd0);
    chk("busy_cleared", 32'(s_rs1_busy), 32'd0);
    chk("reissue_ok", 32'(s_issue_ready), 32'd1);

    // x0 write
    step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("x0_ready", 32'(s_a_ready), 32'd1);
    chk("x0_busy", 32'(s_rs1_busy), 32'd0);
    idle(5'd0);
    chk("x0_no_regwrite", 32'(s_regwrite), 32'd0);

    // Issue in the same cycle as the retiring grant
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd0);
    step(1'b1, 5'd7, 32'h0000_7777, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0);
    chk("same_cycle_issue", 32'(s_issue_ready), 32'd1);
    idle(5'd7);
    chk("set_wins", 32'(s_rs1_busy), 32'd1);

    // Randomized traffic with a held-until-ready handshake
    ra_v = 1'b0; rb_v = 1'b0;
    ra_rd = '0; rb_rd = '0; ra_d = '0; rb_d = '0;
    m_ga = 1'b0; m_gb = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!ra_v || m_ga) begin
        ra_v  = ($urandom_range(0, 2) != 0);
        ra_rd = 5'($urandom_range(0, 7));
        ra_d  = $urandom;
      end
      if (!rb_v || m_gb) begin
        rb_v  = ($urandom_range(0, 1) == 1);
        rb_rd = 5'($urandom_range(0, 7));
        rb_d  = $urandom;
      end
      step(ra_v, ra_rd, ra_d, rb_v, rb_rd, rb_d,
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    // Reset with a write staged: everything drops at once, nothing follows
    step(1'b1, 5'd9, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    chk("staged_before_reset", 32'(RegWrite), 32'd1);
    a_valid = 1'b0; b_valid = 1'b0; issue_valid = 1'b0; rs1 = 5'd9;
    mon_en = 1'b0;
    exp_q.delete();
    reset = 1'b0;
    #1;
    chk("async_reset_regwrite", 32'(RegWrite), 32'd0);
    chk("async_reset_rd", 32'(rd), 32'd0);
    chk("async_reset_wdata", write_data, 32'd0);
    chk("async_reset_pending", 32'(rs1_busy), 32'd0);
    pend = '0;
    b_losses = 0;
    idle(5'd9);
    idle(5'd9);
    @(posedge clk);
    #1;
    reset = 1'b1;
    mon_en = 1'b1;
    repeat (3) idle(5'd9);

    // Short post-reset burst, then drain
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 5'(i % 8), $urandom, (i % 3) == 0, 5'd6, 32'h6666_0000 + 32'(i),
           1'b1, 5'(i % 8), 5'(i % 8), 5'd6);
    end
    repeat (3) idle(5'd0);
    chk("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
